// File: rtl/register_file_v3.sv
// register_file_v3: NUM_REGS x WIDTH register file, 2 sync read ports, forwarding, pending bits; REGFILE_ZERO_REG_EN hardwires reg 0.
module register_file_v3 #(
  parameter int WIDTH    = 16,
  parameter int NUM_REGS = 10,
  parameter int SEL_W    = 4
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [SEL_W-1:0]    RdSelA,
  input  logic [SEL_W-1:0]    RdSelB,
  input  logic                RdEn,
  output logic [WIDTH-1:0]    RdDataA,
  output logic [WIDTH-1:0]    RdDataB,
  output logic                RdErr,
  input  logic [SEL_W-1:0]    WrSel,
  input  logic [WIDTH-1:0]    WrData,
  input  logic                WrEn,
  input  logic                ResvEn,
  input  logic [SEL_W-1:0]    ResvSel,
  output logic [NUM_REGS-1:0] Pending,
  output logic                StallA,
  output logic                StallB
);
`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif
  logic [NUM_REGS-1:0][WIDTH-1:0] regs_q, regs_d, fwd;
  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic [WIDTH-1:0] rd_a_q, rd_a_d, rd_b_q, rd_b_d, val_a, val_b;
  logic err_q, err_d, ok_a, ok_b, pend_a, pend_b;
  // selects that match no register fall through to zero data, no stall and an error flag
  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    fwd    = regs_q;
    val_a  = '0;
    val_b  = '0;
    ok_a   = 1'b0;
    ok_b   = 1'b0;
    pend_a = 1'b0;
    pend_b = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (WrEn && WrSel == SEL_W'(i)) begin
        fwd[i]    = WrData;
        regs_d[i] = WrData;
        pend_d[i] = 1'b0;
      end
      if (ResvEn && ResvSel == SEL_W'(i)) pend_d[i] = 1'b1;
      if (ZERO_REG && i == 0) begin
        fwd[i]    = '0;
        regs_d[i] = '0;
        pend_d[i] = 1'b0;
      end
      if (RdSelA == SEL_W'(i)) begin
        ok_a   = 1'b1;
        val_a  = fwd[i];
        pend_a = pend_q[i];
      end
      if (RdSelB == SEL_W'(i)) begin
        ok_b   = 1'b1;
        val_b  = fwd[i];
        pend_b = pend_q[i];
      end
    end
    rd_a_d = RdEn ? val_a : rd_a_q;
    rd_b_d = RdEn ? val_b : rd_b_q;
    err_d  = RdEn ? !(ok_a && ok_b) : err_q;
  end
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      regs_q <= '0;
      pend_q <= '0;
      rd_a_q <= '0;
      rd_b_q <= '0;
      err_q  <= 1'b0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
      rd_a_q <= rd_a_d;
      rd_b_q <= rd_b_d;
      err_q  <= err_d;
    end
  end
  assign RdDataA = rd_a_q;
  assign RdDataB = rd_b_q;
  assign RdErr   = err_q;
  assign Pending = pend_q;
  assign StallA  = RdEn && pend_a;
  assign StallB  = RdEn && pend_b;
endmodule

// File: tb/tb_register_file_v3.sv
// tb_register_file_v3: scoreboard bench for register_file_v3 with a behavioural reference model.
module tb_register_file_v3;
`ifdef REGFILE_ZERO_REG_EN
  localparam bit Z = 1'b1;
`else
  localparam bit Z = 1'b0;
`endif
  localparam int N = 10;
  logic CLK = 1'b0, RST_N, RdEn, WrEn, ResvEn, RdErr, StallA, StallB;
  logic [3:0] RdSelA, RdSelB, WrSel, ResvSel;
  logic [15:0] WrData, RdDataA, RdDataB;
  logic [9:0] Pending;
  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        err;
    logic [9:0]  pend;
  } exp_t;
  exp_t sb[$];
  logic [15:0] m_regs[N];
  logic [9:0] m_pend;
  logic [15:0] m_a, m_b;
  logic m_err;
  int checks = 0, errors = 0;

  register_file_v3 dut (
    .CLK(CLK), .RST_N(RST_N), .RdSelA(RdSelA), .RdSelB(RdSelB), .RdEn(RdEn),
    .RdDataA(RdDataA), .RdDataB(RdDataB), .RdErr(RdErr), .WrSel(WrSel),
    .WrData(WrData), .WrEn(WrEn), .ResvEn(ResvEn), .ResvSel(ResvSel),
    .Pending(Pending), .StallA(StallA), .StallB(StallB)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mval(input logic [3:0] s);
    if (s >= N || (Z && s == 0)) return '0;
    if (WrEn && WrSel == s) return WrData;
    return m_regs[s];
  endfunction

  task automatic cyc(input logic rst, input logic rden, input logic [3:0] sa, input logic [3:0] sbl,
                     input logic wen, input logic [3:0] ws, input logic [15:0] wd,
                     input logic ren, input logic [3:0] rs);
    logic [15:0] na, nb;
    logic ne;
    @(negedge CLK);
    RST_N = rst; RdEn = rden; RdSelA = sa; RdSelB = sbl;
    WrEn = wen; WrSel = ws; WrData = wd; ResvEn = ren; ResvSel = rs;
    #1;
    check("stall_a", StallA, rden && (sa < N) && m_pend[sa]);
    check("stall_b", StallB, rden && (sbl < N) && m_pend[sbl]);
    na = rden ? mval(sa) : m_a;
    nb = rden ? mval(sbl) : m_b;
    ne = rden ? (sa >= N || sbl >= N) : m_err;
    @(posedge CLK);
    if (!rst) begin
      foreach (m_regs[i]) m_regs[i] = '0;
      m_pend = '0; m_a = '0; m_b = '0; m_err = 1'b0;
    end else begin
      m_a = na; m_b = nb; m_err = ne;
      if (wen && ws < N && !(Z && ws == 0)) begin
        m_regs[ws] = wd;
        m_pend[ws] = 1'b0;
      end
      if (ren && rs < N && !(Z && rs == 0)) m_pend[rs] = 1'b1;
    end
    sb.push_back('{m_a, m_b, m_err, m_pend});
  endtask

  always @(negedge CLK) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("rd_a", RdDataA, e.a);
      check("rd_b", RdDataB, e.b);
      check("rd_err", RdErr, e.err);
      check("pending", Pending, e.pend);
    end
  end

  initial begin
    RST_N = 1'b0; RdEn = 0; WrEn = 0; ResvEn = 0;
    RdSelA = 0; RdSelB = 0; WrSel = 0; ResvSel = 0; WrData = 0;
    foreach (m_regs[i]) m_regs[i] = '0;
    m_pend = '0; m_a = '0; m_b = '0; m_err = 1'b0;
    cyc(0, 1, 3, 9, 1, 3, 16'h1234, 1, 4);
    cyc(0, 1, 3, 9, 1, 9, 16'h5678, 1, 9);
    cyc(1, 1, 3, 9, 0, 0, 0, 0, 0);
    #2 check("rst_rd_a", RdDataA, 0);
    check("rst_rd_b", RdDataB, 0);
    check("rst_pend", Pending, 0);
    cyc(1, 0, 0, 0, 1, 5, 16'hBEEF, 0, 0);
    cyc(1, 1, 5, 4, 0, 0, 0, 0, 0);
    #2 check("beef", RdDataA, 16'hBEEF);
    check("reg4_untouched", RdDataB, 0);
    cyc(1, 0, 0, 0, 1, 2, 16'h1111, 0, 0);
    cyc(1, 1, 2, 2, 1, 2, 16'h2222, 0, 0);
    #2 check("fwd_a", RdDataA, 16'h2222);
    check("fwd_b", RdDataB, 16'h2222);
    cyc(1, 0, 0, 0, 1, 1, 16'h0101, 0, 0);
    cyc(1, 1, 12, 1, 0, 0, 0, 0, 0);
    #2 check("oor_a", RdDataA, 0);
    check("oor_b", RdDataB, 16'h0101);
    check("oor_err", RdErr, 1);
    cyc(1, 0, 0, 0, 1, 15, 16'hABCD, 0, 0);
    #2 check("err_hold", RdErr, 1);
    for (int r = 0; r < 16; r += 2) cyc(1, 1, 4'(r), 4'(r + 1), 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 7);
    cyc(1, 1, 7, 3, 0, 0, 0, 0, 0);
    #2 check("pend7_set", Pending[7], 1);
    cyc(1, 1, 7, 7, 1, 7, 16'h7777, 0, 0);
    #2 check("pend7_clr", Pending[7], 0);
    cyc(1, 1, 7, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 7, 16'h7070, 1, 7);
    #2 check("resv_wins", Pending[7], 1);
    cyc(1, 1, 7, 7, 0, 0, 0, 1, 3);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 check("rst_cancel", Pending, 0);
    cyc(1, 1, 0, 1, 1, 0, 16'hFFFF, 1, 0);
    #2 check("zero_fwd", RdDataA, Z ? 16'h0000 : 16'hFFFF);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
    #2 check("zero_rd", RdDataA, Z ? 16'h0000 : 16'hFFFF);
    check("zero_pend", Pending[0], Z ? 1'b0 : 1'b1);
    for (int k = 0; k < 300; k++)
      cyc(($urandom_range(0, 40) != 0), 1'($urandom), 4'($urandom), 4'($urandom_range(0, 10)),
          1'($urandom), 4'($urandom_range(0, 11)), 16'($urandom), 1'($urandom), 4'($urandom_range(0, 11)));
    @(negedge CLK);
    @(negedge CLK);
    check("drain", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/register_file_v3.md
Name: register_file_v3

Overview:
- Parametrised multi-port register file for the 16-bit datapath.
- Replaces the fixed 10-entry combinational register select with NUM_REGS-deep storage, two synchronous read ports, one write port and write-to-read forwarding.
- Keeps a per-register pending (scoreboard) bit so the control unit can stall on registers awaiting a multi-cycle result.
- Sits between decode and the ALU operand latches.

Parameters:
- WIDTH, 16, data width of each register in bits
- NUM_REGS, 10, number of registers; legal range 2..16
- SEL_W, 4, select width; must satisfy 2^SEL_W >= NUM_REGS

Ports:
- CLK  input  1  rising-edge clock
- RST_N  input  1  synchronous, active-low reset
- RdSelA  input  SEL_W  read port A register select
- RdSelB  input  SEL_W  read port B register select
- RdEn  input  1  capture new read data on both ports this cycle
- RdDataA  output  WIDTH  registered read data, port A
- RdDataB  output  WIDTH  registered read data, port B
- RdErr  output  1  registered; a select captured in the last RdEn cycle was out of range
- WrSel  input  SEL_W  write register select
- WrData  input  WIDTH  write data
- WrEn  input  1  write strobe
- ResvEn  input  1  set the pending bit of register ResvSel
- ResvSel  input  SEL_W  register to reserve
- Pending  output  NUM_REGS  per-register pending bits, registered
- StallA  output  1  combinational; Pending[RdSelA] and RdEn
- StallB  output  1  combinational; Pending[RdSelB] and RdEn

Behaviour:
- Reset: one clock CLK; reset RST_N is synchronous and active-low.
  - Sampled only on the CLK rising edge.
  - While RST_N=0 at an edge: all registers, RdDataA, RdDataB, RdErr and Pending clear to 0.
  - Writes, reservations and reads in that cycle are discarded.
  - A reset asserted mid-sequence cancels all outstanding reservations.
- Write: if WrEn=1 and WrSel<NUM_REGS at an edge, reg[WrSel] <= WrData. The write also clears Pending[WrSel].
  - Out-of-range WrSel: no register change, no Pending change, silently dropped.
- Read, latency 1:
  - If RdEn=1 at an edge, RdDataA <= value(RdSelA) and RdDataB <= value(RdSelB).
  - If RdEn=0, RdDataA and RdDataB hold their previous values.
- Forwarding: if WrEn=1 and WrSel equals a read select in the same cycle, that port captures WrData, not the stale register.
- Out-of-range read select: that port captures 0 and RdErr <= 1. RdErr <= 0 on any RdEn cycle with both selects legal. RdErr holds when RdEn=0.
  - No output is left unassigned for any select value; no latches are inferred.
- Reservation: if ResvEn=1 and ResvSel<NUM_REGS, Pending[ResvSel] <= 1.
- Same register reserved and written in the same cycle: reserve wins and Pending stays 1. This models the issue of a new long op to the same destination.
- Stall outputs: StallA/StallB reflect Pending as of the current cycle.
  - A register being written this cycle still reports stall; it releases the following cycle.
  - Out-of-range selects never stall.
- Two ports reading the same register are legal and return identical data.

Optional Feature:
- Macro: REGFILE_ZERO_REG_EN
- Defined:
  - Register 0 is hardwired to 0 and reads always return 0.
  - Writes to 0 are ignored, including forwarding: a same-cycle write to 0 forwards 0.
  - ResvEn on register 0 is ignored, so Pending[0] is constantly 0.
- Not defined: register 0 is an ordinary register.

Test Plan:
- Reset then read: RST_N=0 for 2 cycles, then RdEn=1, RdSelA=3, RdSelB=9 -> next cycle RdDataA=0, RdDataB=0, RdErr=0, Pending=0.
- Write then read: WrEn=1, WrSel=5, WrData=16'hBEEF; next cycle RdEn=1, RdSelA=5 -> RdDataA=16'hBEEF one cycle later; other registers unchanged.
- Forwarding: reg[2]=16'h1111; same cycle WrEn=1, WrSel=2, WrData=16'h2222, RdEn=1, RdSelA=2, RdSelB=2 -> RdDataA=RdDataB=16'h2222.
- Out of range (NUM_REGS=10): RdEn=1, RdSelA=4'd12, RdSelB=1 -> RdDataA=0, RdDataB=reg[1], RdErr=1. Then WrEn=1, WrSel=4'd15 -> no register changes.
- Scoreboard: ResvEn=1, ResvSel=7; next cycle RdEn=1, RdSelA=7 -> StallA=1. WrEn=1, WrSel=7 -> Pending[7]=0 next cycle and StallA=0. Simultaneous ResvEn=1 and WrEn=1 on 7 -> Pending[7] stays 1.
- REGFILE_ZERO_REG_EN defined: WrEn=1, WrSel=0, WrData=16'hFFFF with RdSelA=0 -> RdDataA=0 that cycle and after; ResvEn on 0 -> Pending[0]=0. Not defined -> RdDataA=16'hFFFF.
